// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver with an AXI-Stream byte output.
// Synchronises and de-glitches the PS/2 lines, then decodes 11-bit frames.
//
// Parameters:
//   FILTER_LEN     equal synchronised samples needed to move the filtered clock
//   TIMEOUT_CYCLES idle cycles after which a partial frame is abandoned
//
// Ports:
//   axis_aclk_i      single rising-edge clock
//   axis_aresetn_i   asynchronous active-low reset
//   ps2_clk_i        raw PS/2 clock pin (asynchronous)
//   ps2_data_i       raw PS/2 data pin (asynchronous)
//   m_axis_tready_i  downstream ready
//   m_axis_tvalid_o  scan-code byte valid
//   m_axis_tdata_o   scan-code byte
//   frame_err_o      one-cycle pulse: bad stop bit, bad parity or timeout
//   overrun_o        one-cycle pulse: good byte dropped, output still held
//
// Build option:
//   PS2_PARITY_CHECK_EN  when defined, frames failing odd parity are
//                        rejected; otherwise the parity bit is ignored.

module ps2_frame_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       axis_aclk_i,
  input  logic       axis_aresetn_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic       m_axis_tready_i,
  output logic       m_axis_tvalid_o,
  output logic [7:0] m_axis_tdata_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  // ------------------------------------------------------------
  // Synchronisers: idle bus level is high, so reset to 1 keeps
  // reset release from looking like a falling clock edge.
  // ------------------------------------------------------------
  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       clk_s;
  logic       dat_s;

  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_i};
      dat_sync <= {dat_sync[0], ps2_data_i};
    end
  end

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  // ------------------------------------------------------------
  // Clock filter: count consecutive samples that disagree with
  // the filtered level; flip only on the FILTER_LEN-th one.
  // ------------------------------------------------------------
  logic [FW-1:0] fcnt;
  logic          filt;
  logic          filt_d;
  logic          fall;

  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) begin
      fcnt   <= '0;
      filt   <= 1'b1;
      filt_d <= 1'b1;
    end else begin
      filt_d <= filt;
      if (clk_s == filt) begin
        fcnt <= '0;
      end else if (fcnt == FMAX) begin
        fcnt <= '0;
        filt <= clk_s;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  assign fall = filt_d & ~filt;

  // ------------------------------------------------------------
  // Frame FSM
  // ------------------------------------------------------------
  state_t        state;
  state_t        state_n;
  logic [2:0]    bcnt;
  logic [2:0]    bcnt_n;
  logic [7:0]    shreg;
  logic [7:0]    shreg_n;
  logic          par;
  logic          par_n;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] tcnt_n;
  logic          par_ok;
  logic          good;
  logic          bad;
  logic          tout;

`ifdef PS2_PARITY_CHECK_EN
  // Odd parity over data plus parity bit means XOR of all nine is 1.
  assign par_ok = ^{shreg, par};
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) begin
      state <= IDLE;
      bcnt  <= '0;
      shreg <= '0;
      par   <= 1'b0;
      tcnt  <= '0;
    end else begin
      state <= state_n;
      bcnt  <= bcnt_n;
      shreg <= shreg_n;
      par   <= par_n;
      tcnt  <= tcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    shreg_n = shreg;
    par_n   = par;
    tcnt_n  = '0;
    good    = 1'b0;
    bad     = 1'b0;
    tout    = 1'b0;

    // Inactivity counter runs only while a frame is in flight.
    if (state != IDLE) begin
      tcnt_n = fall ? '0 : tcnt + TW'(1);
    end

    unique case (state)
      IDLE: begin
        if (fall && !dat_s) begin
          state_n = DATA;
          bcnt_n  = '0;
          shreg_n = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shreg_n = {dat_s, shreg[7:1]};
          bcnt_n  = bcnt + 3'd1;
          if (bcnt == 3'd7) begin
            state_n = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          par_n   = dat_s;
          state_n = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_n = IDLE;
          if (dat_s && par_ok) begin
            good = 1'b1;
          end else begin
            bad = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if ((state != IDLE) && !fall && (tcnt == TMAX)) begin
      tout    = 1'b1;
      state_n = IDLE;
      bcnt_n  = '0;
      shreg_n = '0;
      tcnt_n  = '0;
    end
  end

  // ------------------------------------------------------------
  // Output register and status pulses
  // ------------------------------------------------------------
  logic       tvalid_n;
  logic [7:0] tdata_n;
  logic       ferr_n;
  logic       ovr_n;

  always_comb begin
    tvalid_n = m_axis_tvalid_o & ~m_axis_tready_i;
    tdata_n  = m_axis_tdata_o;
    ferr_n   = bad | tout;
    ovr_n    = 1'b0;
    if (good) begin
      // Slot is free if empty or being drained this same cycle.
      if (!m_axis_tvalid_o || m_axis_tready_i) begin
        tvalid_n = 1'b1;
        tdata_n  = shreg;
      end else begin
        ovr_n = 1'b1;
      end
    end
  end

  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) begin
      m_axis_tvalid_o <= 1'b0;
      m_axis_tdata_o  <= 8'h00;
      frame_err_o     <= 1'b0;
      overrun_o       <= 1'b0;
    end else begin
      m_axis_tvalid_o <= tvalid_n;
      m_axis_tdata_o  <= tdata_n;
      frame_err_o     <= ferr_n;
      overrun_o       <= ovr_n;
    end
  end

endmodule

// File: doc/ps2_frame_rx.md
PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 8: consecutive identical samples required before the filtered PS/2 clock changes level.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 50000: idle cycles (1 ms at 50 MHz) after which a partial frame is abandoned.
REQ-003 The block SHALL have port axis_aclk_i, input, 1: single clock; all logic on rising edge.
REQ-004 The block SHALL have port axis_aresetn_i, input, 1: reset, asynchronous, active-low.
REQ-005 The block SHALL have port ps2_clk_i, input, 1: raw PS/2 clock pin, asynchronous.
REQ-006 The block SHALL have port ps2_data_i, input, 1: raw PS/2 data pin, asynchronous.
REQ-007 The block SHALL have port m_axis_tready_i, input, 1: downstream AXIS consumer ready.
REQ-008 The block SHALL have port m_axis_tvalid_o, output, 1: scan-code byte valid.
REQ-009 The block SHALL have port m_axis_tdata_o, output, 8: received scan-code byte.
REQ-010 The block SHALL have port frame_err_o, output, 1: one-cycle pulse on a bad stop bit, bad parity or timeout.
REQ-011 The block SHALL have port overrun_o, output, 1: one-cycle pulse when a good byte is dropped.

Function
REQ-012 Synchronisation: ps2_clk_i and ps2_data_i SHALL each pass through a 2-flop synchroniser before any use.
REQ-013 Clock filter: the filtered clock SHALL take the synchronised level only after FILTER_LEN consecutive equal samples; shorter glitches SHALL be ignored.
REQ-014 Edge strobe: a one-cycle fall strobe SHALL be generated on each filtered-clock 1->0 transition; data SHALL be sampled (synchronised) on that cycle.
REQ-015 FSM states SHALL be IDLE, DATA, PARITY and STOP.
REQ-016 IDLE: on a strobe with data=0, go to DATA and set bit count to 0; on a strobe with data=1, stay in IDLE with no error.
REQ-017 DATA: each strobe SHALL shift data in LSB first; after the 8th bit, go to PARITY.
REQ-018 PARITY: a strobe SHALL capture the parity bit and go to STOP.
REQ-019 STOP: a strobe SHALL evaluate the frame and return to IDLE; the frame is good if stop=1 and the 9 bits have odd parity (see REQ-029/030).
REQ-020 Timeout: in DATA, PARITY or STOP, a cycle counter SHALL clear on each strobe; on reaching TIMEOUT_CYCLES it SHALL force IDLE, discard the partial byte and pulse frame_err_o.
REQ-021 Bad frame: frame_err_o SHALL pulse for one cycle, the cycle after the STOP strobe; output registers SHALL be unchanged.
REQ-022 Good frame, output register empty or being accepted this cycle: m_axis_tdata_o SHALL load the byte and m_axis_tvalid_o SHALL be 1 on the cycle after the STOP strobe (latency 1).
REQ-023 Handshake: a transfer occurs on a cycle with tvalid=1 and tready=1; tvalid SHALL then drop the next cycle unless REQ-022 reloads it.
REQ-024 While tvalid=1 and tready=0, tdata and tvalid SHALL be held stable.
REQ-025 Overrun: on a good frame while tvalid=1 and tready=0, the new byte SHALL be dropped, the held byte kept, and overrun_o pulsed for one cycle.
REQ-026 Simultaneous events: a transfer and a good frame in the same cycle SHALL load the new byte with tvalid staying 1 and no overrun.

Reset
REQ-027 While axis_aresetn_i=0, the block SHALL asynchronously clear: FSM to IDLE; bit and timeout counters to 0; shift register to 0; m_axis_tvalid_o, frame_err_o and overrun_o to 0; m_axis_tdata_o to 8'h00.
REQ-028 The synchroniser and filter SHALL reset to the high level, so release under an idle bus produces no strobe; reset mid-frame SHALL discard the frame without an error pulse.

Configuration
REQ-029 With macro PS2_PARITY_CHECK_EN defined, a frame with even parity over data+parity SHALL be treated as bad (REQ-021).
REQ-030 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be captured but ignored, and only the stop bit SHALL decide validity.

Verification
REQ-031 Verification: valid frame for 8'h1C (parity 0, stop 1), 10 us clock period, tready=1 -> tvalid one cycle with tdata=8'h1C, no error pulses.
REQ-032 Verification: frame 8'h1C with parity=1, macro defined -> frame_err_o one pulse, tvalid stays 0; same frame without the macro -> byte 8'h1C delivered.
REQ-033 Verification: tready=0, frames 8'h1C then 8'hF0 -> tdata holds 8'h1C, overrun_o pulses once; tready=1 then yields 8'h1C only.
REQ-034 Verification: a 4-bit partial frame then bus idle for 1.5 ms -> frame_err_o pulses once at TIMEOUT_CYCLES; next full frame 8'h29 is received correctly.
REQ-035 Verification: 3-cycle low glitches on ps2_clk_i while idle -> no state change and no outputs; axis_aresetn_i low mid-frame -> all outputs 0, the next frame is received cleanly.
REQ-036 Verification: tready asserted on the same cycle a new good frame completes -> both bytes transferred in order, no overrun.
